fb_rect_writer: RTL

// Framebuffer write-side engine: accepts filled-rectangle draw commands over a

---
 rtl/fb_rect_writer_pkg.sv | 27 ++
 rtl/fb_rect_writer_if.sv | 22 ++
 rtl/fb_rect_writer_clip.sv | 50 +++++
 rtl/fb_rect_writer.sv | 108 ++++++++++
 4 files changed

// File: rtl/fb_rect_writer_pkg.sv
// rtl/fb_rect_writer_pkg.sv - shared widths, FSM states and command struct for the rectangle writer
package fb_pkg;
   localparam int CORDW     = 11;
   localparam int CIDXW     = 4;
   localparam int FB_WIDTH  = 160;
   localparam int FB_HEIGHT = 120;
   localparam int FB_ADDRW  = 15;
   localparam int FB_XW     = 8;
   localparam int FB_YW     = 7;

   typedef enum logic [2:0] {IDLE, CLIP, WAITF, DRAW, DONE} fbw_state_t;

   typedef struct packed {
      logic signed [CORDW-1:0] x0;
      logic signed [CORDW-1:0] y0;
      logic signed [CORDW-1:0] x1;
      logic signed [CORDW-1:0] y1;
      logic [CIDXW-1:0]        cidx;
   } fb_rect_t;

   // y*160 as y*128 + y*32 so no multiplier is needed
   function automatic logic [FB_ADDRW-1:0] row_base_of(input logic [FB_YW-1:0] y);
      logic [FB_ADDRW-1:0] v;
      v = FB_ADDRW'(y);
      return (v << 7) + (v << 5);
   endfunction
endpackage

// File: rtl/fb_rect_writer_if.sv
// rtl/fb_rect_writer_if.sv - rectangle draw command valid/ready channel
interface fb_rect_writer_if;
   import fb_pkg::*;

   logic                    cmd_valid;
   logic                    cmd_ready;
   logic signed [CORDW-1:0] cmd_x0;
   logic signed [CORDW-1:0] cmd_y0;
   logic signed [CORDW-1:0] cmd_x1;
   logic signed [CORDW-1:0] cmd_y1;
   logic [CIDXW-1:0]        cmd_cidx;

   modport master (
      output cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_cidx,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_cidx,
      output cmd_ready
   );
endinterface

// File: rtl/fb_rect_writer_clip.sv
// rtl/fb_rect_writer_clip.sv - registers the command clipped to the framebuffer plus an empty flag
module fb_rect_clip
   import fb_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  fb_rect_t         i_rect,
   output logic [FB_XW-1:0] o_xs,
   output logic [FB_XW-1:0] o_xe,
   output logic [FB_YW-1:0] o_ys,
   output logic [FB_YW-1:0] o_ye,
   output logic [CIDXW-1:0] o_cidx,
   output logic             o_empty
);
   localparam logic signed [CORDW-1:0] C_ZERO = '0;
   localparam logic signed [CORDW-1:0] C_XMAX = CORDW'(FB_WIDTH - 1);
   localparam logic signed [CORDW-1:0] C_YMAX = CORDW'(FB_HEIGHT - 1);

   logic signed [CORDW-1:0] w_xs, w_xe, w_ys, w_ye;
   logic                    w_empty;

   always_comb begin
      w_xs = (i_rect.x0 < C_ZERO) ? C_ZERO : i_rect.x0;
      w_ys = (i_rect.y0 < C_ZERO) ? C_ZERO : i_rect.y0;
      w_xe = (i_rect.x1 > C_XMAX) ? C_XMAX : i_rect.x1;
      w_ye = (i_rect.y1 > C_YMAX) ? C_YMAX : i_rect.y1;
      // full-width signed compares catch rectangles entirely off any edge
      w_empty = (i_rect.x0 > i_rect.x1) || (i_rect.y0 > i_rect.y1) ||
                (w_xe < w_xs) || (w_ye < w_ys);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         o_xs    <= '0;
         o_xe    <= '0;
         o_ys    <= '0;
         o_ye    <= '0;
         o_cidx  <= '0;
         o_empty <= 1'b0;
      end else if (i_load) begin
         o_xs    <= w_xs[FB_XW-1:0];
         o_xe    <= w_xe[FB_XW-1:0];
         o_ys    <= w_ys[FB_YW-1:0];
         o_ye    <= w_ye[FB_YW-1:0];
         o_cidx  <= i_rect.cidx;
         o_empty <= w_empty;
      end
   end
endmodule

// File: rtl/fb_rect_writer.sv
// rtl/fb_rect_writer.sv - clips filled-rectangle commands and streams one framebuffer write per cycle
module fb_rect_writer
   import fb_pkg::*;
#(
   parameter int WAIT_FRAME = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                frame_sys,
   fb_rect_writer_if.slave     cmd,
   output logic                we,
   output logic [FB_ADDRW-1:0] addr_write,
   output logic [CIDXW-1:0]    data_in,
   output logic                busy,
   output logic                done
);
   fbw_state_t          r_state, w_state_nxt;
   logic [FB_XW-1:0]    r_x;
   logic [FB_YW-1:0]    r_y;
   logic [FB_ADDRW-1:0] r_row_base;

   logic [FB_XW-1:0]    w_xs, w_xe;
   logic [FB_YW-1:0]    w_ys, w_ye;
   logic [CIDXW-1:0]    w_cidx;
   logic                w_empty, w_ready, w_accept, w_last;
   fb_rect_t            w_rect;

   assign w_rect    = '{x0: cmd.cmd_x0, y0: cmd.cmd_y0, x1: cmd.cmd_x1,
                        y1: cmd.cmd_y1, cidx: cmd.cmd_cidx};
   assign w_accept  = cmd.cmd_valid && w_ready;
   assign w_last    = (r_x == w_xe) && (r_y == w_ye);
   assign cmd.cmd_ready = w_ready;

   fb_rect_clip u_clip (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_accept),
      .i_rect  (w_rect),
      .o_xs    (w_xs),
      .o_xe    (w_xe),
      .o_ys    (w_ys),
      .o_ye    (w_ye),
      .o_cidx  (w_cidx),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // raster walk: x fastest, row base advances by one line per row
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_x        <= '0;
         r_y        <= '0;
         r_row_base <= '0;
      end else if (r_state == CLIP) begin
         r_x        <= w_xs;
         r_y        <= w_ys;
         r_row_base <= row_base_of(w_ys);
      end else if (r_state == DRAW && !w_last) begin
         if (r_x == w_xe) begin
            r_x        <= w_xs;
            r_y        <= r_y + 1'b1;
            r_row_base <= r_row_base + FB_ADDRW'(FB_WIDTH);
         end else begin
            r_x <= r_x + 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ready     = 1'b0;
      we          = 1'b0;
      busy        = 1'b1;
      done        = 1'b0;
      addr_write  = '0;
      data_in     = '0;
      unique case (r_state)
         IDLE: begin
            w_ready = 1'b1;
            busy    = 1'b0;
            if (cmd.cmd_valid) w_state_nxt = CLIP;
         end
         CLIP: begin
            if (w_empty)              w_state_nxt = DONE;
            else if (WAIT_FRAME != 0) w_state_nxt = WAITF;
            else                      w_state_nxt = DRAW;
         end
         WAITF: begin
            if (frame_sys) w_state_nxt = DRAW;
         end
         DRAW: begin
            we         = 1'b1;
            addr_write = r_row_base + FB_ADDRW'(r_x);
            data_in    = w_cidx;
            if (w_last) w_state_nxt = DONE;
         end
         DONE: begin
            done        = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end
endmodule
